pong_frame_renderer: RTL and testbench
======================================

# pong_frame_renderer

Parametrised raster renderer for the Pong LED matrix. On each frame request it snapshots game state (ball, paddles, scores), clamps paddles to the legal range, and streams the frame one pixel per accepted handshake in row-major order over a valid/ready interface to the matrix driver. Replaces whole-array matrix generation with a tear-free, backpressure-aware pixel stream whose geometry is set by parameters.

## Interface
- COLS, 64, matrix width; XW = $clog2(COLS)
- ROWS, 64, matrix height; YW = $clog2(ROWS)
- PAD_LEN, 6, paddle height in pixels
- PAD_W, 2, paddle width in pixels
- P1_X, 0, left column of paddle 1
- P2_X, COLS-2, left column of paddle 2
- PAD_MIN, 5, lowest legal paddle top row
- PAD_MAX, ROWS-PAD_LEN, highest legal paddle top row
- MID_X, 30, left column of centre line; MID_W, 2, its width
- DASH_PERIOD, 3, centre-line period in rows; DASH_ON, 2, lit rows per period
- SC1_X, 14; SC2_X, 46; SC_Y, 1: top-left corner of the 3x5 score glyphs
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  single-cycle frame request
- bx  in  XW  ball column; by  in  YW  ball row
- p1y, p2y  in  YW  paddle top rows, unclamped
- sc1, sc2  in  3  scores 0..7
- show_mid  in  1  enable centre line (sampled with snapshot)
- show_score  in  1  enable score glyphs (sampled with snapshot)
- pix_valid  out  1  pixel available
- pix_ready  in  1  downstream accepts pixel
- pix_data  out  1  pixel on/off
- pix_x  out  XW; pix_y  out  YW  coordinate of current pixel
- pix_eol  out  1  current pixel is last in its row (pix_x == COLS-1)
- pix_last  out  1  current pixel is last in frame
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after last pixel accepted

## Operation
- States: IDLE, SCAN. Reset forces IDLE.
- IDLE: on frame_start, register snapshot of bx, by, sc1, sc2, show_mid, show_score and clamped paddles (p < PAD_MIN -> PAD_MIN; p > PAD_MAX -> PAD_MAX; else p); x=y=0; go SCAN.
- SCAN: pix_valid=1. Handshake = pix_valid & pix_ready. On handshake, x increments; at x==COLS-1, x wraps to 0 and y increments. Dash phase counter increments with y, wrapping at DASH_PERIOD (no divider).
- pix_data = OR of: ball (x==bx & y==by); paddle 1 (P1_X<=x<P1_X+PAD_W, p1<=y<p1+PAD_LEN); paddle 2 likewise; centre line (show_mid, MID_X<=x<MID_X+MID_W, phase<DASH_ON); glyphs (show_score).
- Glyph: 15-bit pattern, bit 14-(3r+c) lights (SCn_X+c, SC_Y+r), r 0..4, c 0..2. Patterns 0..7: 0x7B6F, 0x2492, 0x73E7, 0x73CF, 0x5BC9, 0x79CF, 0x79EF, 0x7249.
- Ball off-matrix (bx>=COLS or by>=ROWS): not drawn, no error.
- Handshake on pix_last: frame_done pulses next cycle; go IDLE, unless frame_start is high that same cycle: then re-snapshot, x=y=0, remain SCAN (back-to-back, no gap).
- frame_start during SCAN otherwise ignored. Input changes after snapshot have no effect until next frame.

## Timing
- Reset values: pix_valid, pix_data, pix_x, pix_y, pix_eol, pix_last, busy, frame_done all 0.
- frame_start sampled at edge N -> pix_valid=1 with (0,0) from cycle N+1.
- Full frame with pix_ready held high: COLS*ROWS cycles.
- While pix_valid & !pix_ready: pix_data, pix_x, pix_y, pix_eol, pix_last stable.
- No combinational path from any input to any output; all outputs are functions of registered state.
- busy = (state==SCAN). frame_done is registered, one cycle wide, asserted the cycle after the final handshake.
- rst_n low mid-frame: immediate return to IDLE, outputs to reset values; pending frame discarded.

## Test plan
- Reset: hold rst_n low with frame_start high -> all outputs 0; release -> IDLE, busy=0.
- Full frame, defaults, ready=1: bx=10, by=20, p1y=3, p2y=60, sc1=0, sc2=7, show_mid=show_score=1 -> 4096 pixels, lit at (10,20), x0-1 y5-10, x62-63 y58-63; total lit count 130; pix_last at (63,63); frame_done 1 cycle later.
- Backpressure: ready low 5 cycles at (10,20) -> pix_data=1, x/y frozen; random ready over a frame -> lit count still 130.
- Back-to-back: frame_start on final-handshake cycle with bx=11 -> next cycle pix_valid=1 at (0,0), ball at (11,20), frame_done still pulses.
- Snapshot isolation: change bx to 40 and pulse frame_start mid-frame -> ball remains at (10,20), no restart.
- Reset mid-frame at pixel 1000 -> outputs 0 asynchronously; next frame_start restarts at (0,0), 4096 pixels.

Source files
------------

// File: rtl/pong_frame_renderer_if.sv
// Pixel stream from the Pong frame renderer to the LED matrix driver.
// Valid/ready handshake carrying one pixel with its coordinate and end-of-row/frame marks.
interface pong_frame_renderer_if #(
    parameter int unsigned COLS = 64,
    parameter int unsigned ROWS = 64
);
    localparam int unsigned XW = $clog2(COLS);
    localparam int unsigned YW = $clog2(ROWS);

    logic          pix_valid;
    logic          pix_ready;
    logic          pix_data;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_eol;
    logic          pix_last;

    modport master (
        output pix_valid, pix_data, pix_x, pix_y, pix_eol, pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_data, pix_x, pix_y, pix_eol, pix_last,
        output pix_ready
    );
endinterface

// File: rtl/pong_frame_renderer.sv
// Raster renderer: snapshots game state on a frame request and streams the frame
// one pixel per handshake in row-major order, with backpressure.
module pong_frame_renderer #(
    parameter int unsigned COLS        = 64,
    parameter int unsigned ROWS        = 64,
    parameter int unsigned PAD_LEN     = 6,
    parameter int unsigned PAD_W       = 2,
    parameter int unsigned P1_X        = 0,
    parameter int unsigned P2_X        = COLS - 2,
    parameter int unsigned PAD_MIN     = 5,
    parameter int unsigned PAD_MAX     = ROWS - PAD_LEN,
    parameter int unsigned MID_X       = 30,
    parameter int unsigned MID_W       = 2,
    parameter int unsigned DASH_PERIOD = 3,
    parameter int unsigned DASH_ON     = 2,
    parameter int unsigned SC1_X       = 14,
    parameter int unsigned SC2_X       = 46,
    parameter int unsigned SC_Y        = 1,
    localparam int unsigned XW         = $clog2(COLS),
    localparam int unsigned YW         = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic [XW-1:0] bx,
    input  logic [YW-1:0] by,
    input  logic [YW-1:0] p1y,
    input  logic [YW-1:0] p2y,
    input  logic [2:0]    sc1,
    input  logic [2:0]    sc2,
    input  logic          show_mid,
    input  logic          show_score,
    pong_frame_renderer_if.master pix,
    output logic          busy,
    output logic          frame_done
);
    localparam int unsigned PW = (DASH_PERIOD > 1) ? $clog2(DASH_PERIOD) : 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d, bx_q, bx_d;
    logic [YW-1:0] y_q, y_d, by_q, by_d, p1_q, p1_d, p2_q, p2_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [2:0]    sc1_q, sc1_d, sc2_q, sc2_d;
    logic          mid_q, mid_d, score_q, score_d;
    logic          frame_done_q, frame_done_d;

    logic x_end, y_end, hs, load, lit;

    function automatic logic [14:0] glyph(input logic [2:0] v);
        unique case (v)
            3'd0: glyph = 15'h7B6F;
            3'd1: glyph = 15'h2492;
            3'd2: glyph = 15'h73E7;
            3'd3: glyph = 15'h73CF;
            3'd4: glyph = 15'h5BC9;
            3'd5: glyph = 15'h79CF;
            3'd6: glyph = 15'h79EF;
            3'd7: glyph = 15'h7249;
        endcase
    endfunction

    // Unsigned wrap makes (v - lo) < len a single-compare range test.
    function automatic logic in_span(input int unsigned v, input int unsigned lo,
                                     input int unsigned len);
        in_span = (v - lo) < len;
    endfunction

    function automatic logic glyph_hit(input int unsigned xi, input int unsigned yi,
                                       input int unsigned gx, input logic [14:0] g);
        int unsigned r, c;
        logic [14:0] sh;
        glyph_hit = 1'b0;
        if (in_span(xi, gx, 3) && in_span(yi, SC_Y, 5)) begin
            r  = yi - SC_Y;
            c  = xi - gx;
            sh = g >> (14 - (3 * r + c));
            glyph_hit = sh[0];
        end
    endfunction

    function automatic logic [YW-1:0] clamp_pad(input logic [YW-1:0] p);
        if (32'(p) < PAD_MIN)      clamp_pad = YW'(PAD_MIN);
        else if (32'(p) > PAD_MAX) clamp_pad = YW'(PAD_MAX);
        else                       clamp_pad = p;
    endfunction

    assign x_end = (32'(x_q) == COLS - 1);
    assign y_end = (32'(y_q) == ROWS - 1);
    assign hs    = (state_q == SCAN) && pix.pix_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            phase_q      <= '0;
            bx_q         <= '0;
            by_q         <= '0;
            p1_q         <= '0;
            p2_q         <= '0;
            sc1_q        <= '0;
            sc2_q        <= '0;
            mid_q        <= 1'b0;
            score_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            phase_q      <= phase_d;
            bx_q         <= bx_d;
            by_q         <= by_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            sc1_q        <= sc1_d;
            sc2_q        <= sc2_d;
            mid_q        <= mid_d;
            score_q      <= score_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        phase_d      = phase_q;
        bx_d         = bx_q;
        by_d         = by_q;
        p1_d         = p1_q;
        p2_d         = p2_q;
        sc1_d        = sc1_q;
        sc2_d        = sc2_q;
        mid_d        = mid_q;
        score_d      = score_q;
        frame_done_d = 1'b0;
        load         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    load    = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (hs) begin
                    if (x_end) begin
                        x_d     = '0;
                        y_d     = y_end ? '0 : y_q + 1'b1;
                        phase_d = (32'(phase_q) == DASH_PERIOD - 1) ? '0 : phase_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                    // A request coinciding with the final handshake chains the next frame.
                    if (x_end && y_end) begin
                        frame_done_d = 1'b1;
                        if (frame_start) load    = 1'b1;
                        else             state_d = IDLE;
                    end
                end
            end
        endcase

        if (load) begin
            x_d     = '0;
            y_d     = '0;
            phase_d = '0;
            bx_d    = bx;
            by_d    = by;
            p1_d    = clamp_pad(p1y);
            p2_d    = clamp_pad(p2y);
            sc1_d   = sc1;
            sc2_d   = sc2;
            mid_d   = show_mid;
            score_d = show_score;
        end
    end

    always_comb begin
        int unsigned xi, yi;
        xi  = 32'(x_q);
        yi  = 32'(y_q);
        lit = 1'b0;
        if (x_q == bx_q && y_q == by_q)                                   lit = 1'b1;
        if (in_span(xi, P1_X, PAD_W) && in_span(yi, 32'(p1_q), PAD_LEN)) lit = 1'b1;
        if (in_span(xi, P2_X, PAD_W) && in_span(yi, 32'(p2_q), PAD_LEN)) lit = 1'b1;
        if (mid_q && in_span(xi, MID_X, MID_W) && 32'(phase_q) < DASH_ON) lit = 1'b1;
        if (score_q && glyph_hit(xi, yi, SC1_X, glyph(sc1_q)))           lit = 1'b1;
        if (score_q && glyph_hit(xi, yi, SC2_X, glyph(sc2_q)))           lit = 1'b1;

        busy          = (state_q == SCAN);
        frame_done    = frame_done_q;
        pix.pix_valid = busy;
        pix.pix_data  = busy && lit;
        pix.pix_x     = x_q;
        pix.pix_y     = y_q;
        pix.pix_eol   = busy && x_end;
        pix.pix_last  = busy && x_end && y_end;
    end
endmodule

// File: tb/tb_pong_frame_renderer.sv
// Directed bench for pong_frame_renderer: expected pixels are queued per frame request
// and popped on every accepted handshake.
module tb_pong_frame_renderer;
    localparam int COLS = 64;
    localparam int ROWS = 64;
    localparam int NPIX = COLS * ROWS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic [5:0] bx = '0, by = '0, p1y = '0, p2y = '0;
    logic [2:0] sc1 = '0, sc2 = '0;
    logic       show_mid = 1'b0, show_score = 1'b0;
    logic       busy, frame_done;

    pong_frame_renderer_if #(.COLS(COLS), .ROWS(ROWS)) pif ();

    pong_frame_renderer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .bx(bx), .by(by), .p1y(p1y), .p2y(p2y), .sc1(sc1), .sc2(sc2),
        .show_mid(show_mid), .show_score(show_score),
        .pix(pif.master), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [5:0] x;
        logic [5:0] y;
        logic       d;
        logic       eol;
        logic       last;
    } pix_t;

    typedef struct {
        int bx, by, p1, p2, sc1, sc2;
        bit mid, score;
    } snap_t;

    pix_t       exp_q[$];
    int         n_assert = 0;
    int         n_fail = 0;
    logic [14:0] GLY [8] = '{15'h7B6F, 15'h2492, 15'h73E7, 15'h73CF,
                            15'h5BC9, 15'h79CF, 15'h79EF, 15'h7249};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int clampp(input int p);
        return (p < 5) ? 5 : ((p > 58) ? 58 : p);
    endfunction

    function automatic bit model(input int x, input int y, input snap_t s);
        int p1 = clampp(s.p1);
        int p2 = clampp(s.p2);
        logic [14:0] g;
        bit on = 1'b0;
        if (x == s.bx && y == s.by) on = 1'b1;
        if (x < 2 && y >= p1 && y < p1 + 6) on = 1'b1;
        if (x >= 62 && y >= p2 && y < p2 + 6) on = 1'b1;
        if (s.mid && (x == 30 || x == 31) && (y % 3) < 2) on = 1'b1;
        if (s.score && y >= 1 && y < 6) begin
            if (x >= 14 && x < 17) begin
                g = GLY[s.sc1];
                if (g[14 - (3 * (y - 1) + (x - 14))]) on = 1'b1;
            end
            if (x >= 46 && x < 49) begin
                g = GLY[s.sc2];
                if (g[14 - (3 * (y - 1) + (x - 46))]) on = 1'b1;
            end
        end
        return on;
    endfunction

    task automatic drive_inputs(input snap_t s);
        bx = 6'(s.bx); by = 6'(s.by); p1y = 6'(s.p1); p2y = 6'(s.p2);
        sc1 = 3'(s.sc1); sc2 = 3'(s.sc2);
        show_mid = s.mid; show_score = s.score;
    endtask

    task automatic push_frame(input snap_t s);
        pix_t e;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                e.x = 6'(x); e.y = 6'(y);
                e.d = model(x, y, s);
                e.eol = (x == COLS - 1);
                e.last = (x == COLS - 1) && (y == ROWS - 1);
                exp_q.push_back(e);
            end
    endtask

    // Called at posedge+1; leaves frame_start high for exactly one edge.
    task automatic start_frame(input snap_t s);
        drive_inputs(s);
        frame_start = 1'b1;
        push_frame(s);
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic run_frame(input int rmode, input int stall_idx, input int poke_idx,
                             input int reset_idx, input bit b2b, input snap_t s2,
                             output int cycles, output int lit, output int popped);
        int   stall = 0;
        bit   stall_done = 1'b0;
        pix_t e, obs;
        cycles = 0; lit = 0; popped = 0;
        while (popped < NPIX && cycles < 20000) begin
            frame_start = 1'b0;
            if (stall > 0) begin
                pif.pix_ready = 1'b0; stall--;
            end else if (popped == stall_idx && !stall_done) begin
                pif.pix_ready = 1'b0; stall = 4; stall_done = 1'b1;
            end else if (rmode == 0) begin
                pif.pix_ready = 1'b1;
            end else begin
                pif.pix_ready = ($urandom_range(0, 1) == 1);
            end
            if (popped == poke_idx && pif.pix_ready) begin
                bx = 6'd40; frame_start = 1'b1;
            end
            if (b2b && popped == NPIX - 1 && pif.pix_ready) begin
                drive_inputs(s2); frame_start = 1'b1; push_frame(s2);
            end
            if (popped == reset_idx) begin
                rst_n = 1'b0;
                #1;
                check("async_reset_outputs",
                      {pif.pix_valid, pif.pix_data, pif.pix_x, pif.pix_y,
                       pif.pix_eol, pif.pix_last, busy, frame_done}, '0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                exp_q.delete();
                return;
            end
            @(negedge clk);
            if (stall_idx >= 0 && popped == stall_idx && !pif.pix_ready && exp_q.size() > 0) begin
                e = exp_q[0];
                check("stall_hold", {pif.pix_valid, pif.pix_data, pif.pix_x, pif.pix_y},
                      {1'b1, e.d, e.x, e.y});
            end
            if (pif.pix_valid && pif.pix_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    obs = {pif.pix_x, pif.pix_y, pif.pix_data, pif.pix_eol, pif.pix_last};
                    check("pixel", obs, e);
                end
                lit += int'(pif.pix_data);
                popped++;
            end
            @(posedge clk); #1;
            cycles++;
        end
        if (popped < NPIX) check("frame_timeout", 32'(popped), 32'(NPIX));
    endtask

    task automatic check_done();
        @(negedge clk);
        check("frame_done_pulse", {frame_done, busy, pif.pix_valid}, 3'b100);
        @(posedge clk); #1;
        @(negedge clk);
        check("frame_done_width", frame_done, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        snap_t d, s2;
        int cyc, lit, pop;
        d = '{bx: 10, by: 20, p1: 3, p2: 60, sc1: 0, sc2: 7, mid: 1'b1, score: 1'b1};
        pif.pix_ready = 1'b1;

        // Reset held with a frame request present
        drive_inputs(d);
        rst_n = 1'b0; frame_start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {pif.pix_valid, pif.pix_data, pif.pix_x, pif.pix_y,
                                pif.pix_eol, pif.pix_last, busy, frame_done}, '0);
        @(posedge clk); #1;
        frame_start = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {busy, pif.pix_valid}, 2'b00);
        @(posedge clk); #1;

        // Full frame, ready held high
        start_frame(d);
        run_frame(0, -1, -1, -1, 1'b0, d, cyc, lit, pop);
        check("full_cycles", 32'(cyc), 32'(NPIX));
        check("full_lit", 32'(lit), 32'd130);
        check_done();

        // Five-cycle stall on the ball pixel
        start_frame(d);
        run_frame(0, 20 * COLS + 10, -1, -1, 1'b0, d, cyc, lit, pop);
        check("stall_cycles", 32'(cyc), 32'(NPIX + 5));
        check("stall_lit", 32'(lit), 32'd130);
        check_done();

        // Random backpressure
        start_frame(d);
        run_frame(1, -1, -1, -1, 1'b0, d, cyc, lit, pop);
        check("random_lit", 32'(lit), 32'd130);
        check("random_count", 32'(pop), 32'(NPIX));
        check_done();

        // Mid-frame input change and frame request are ignored
        start_frame(d);
        run_frame(0, -1, 500, -1, 1'b0, d, cyc, lit, pop);
        check("snapshot_cycles", 32'(cyc), 32'(NPIX));
        check("snapshot_lit", 32'(lit), 32'd130);
        check_done();

        // Back-to-back frames
        s2 = d; s2.bx = 11;
        start_frame(d);
        run_frame(0, -1, -1, -1, 1'b1, s2, cyc, lit, pop);
        frame_start = 1'b0; pif.pix_ready = 1'b0;
        @(negedge clk);
        check("b2b_state", {frame_done, busy, pif.pix_valid, pif.pix_x, pif.pix_y},
              {3'b111, 6'd0, 6'd0});
        check("b2b_queue", 32'(exp_q.size()), 32'(NPIX));
        @(posedge clk); #1;
        run_frame(0, -1, -1, -1, 1'b0, s2, cyc, lit, pop);
        check("b2b_cycles", 32'(cyc), 32'(NPIX));
        check("b2b_lit", 32'(lit), 32'd130);
        check_done();

        // Reset at pixel 1000, then a clean frame
        start_frame(d);
        run_frame(0, -1, -1, 1000, 1'b0, d, cyc, lit, pop);
        check("reset_at", 32'(pop), 32'd1000);
        @(negedge clk);
        check("idle_after_midreset", {busy, pif.pix_valid, frame_done}, 3'b000);
        @(posedge clk); #1;
        start_frame(d);
        run_frame(0, -1, -1, -1, 1'b0, d, cyc, lit, pop);
        check("restart_count", 32'(pop), 32'(NPIX));
        check("restart_cycles", 32'(cyc), 32'(NPIX));
        check_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
